uart_mmio_ctrl: RTL and testbench
=================================

UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

Interface
REQ-001 The module SHALL expose parameter DEPTH, default 16, FIFO entries per direction (power of two, 2..128).
REQ-002 The module SHALL expose parameter ADDR_WIDTH, default 32, bus address width.
REQ-003 The module SHALL have one clock and an asynchronous active-low reset, with ports clk first and reset_n second.
REQ-004 The ports SHALL be: clk  in  1  sole clock; reset_n  in  1  async active-low reset.
REQ-005 The bus ports SHALL be: addr  in  ADDR_WIDTH  byte address; write_data  in  8  write value; write_enable  in  1  write strobe; read_enable  in  1  read strobe; read_data  out  8  combinational read value.
REQ-006 The UART-side ports SHALL be: rx_data  in  8  received byte; rx_data_valid  in  1  one-cycle receive pulse; tx_data  out  8  byte to transmitter; tx_data_valid  out  1  one-cycle start pulse; tx_busy  in  1  transmitter active.
REQ-007 The module SHALL have an irq output: irq  out  1  registered level interrupt.

Function
REQ-008 The register map SHALL be: 0x00 STATUS (RO), 0x04 DATA (RW), 0x08 CTRL (RW), 0x0C IRQ_STAT (R/W1C), 0x10 RX_LEVEL (RO), 0x14 TX_LEVEL (RO); unmapped reads return 0x00 and unmapped writes are ignored.
REQ-009 STATUS SHALL read {3'b0, tx_engine_active, rx_full, tx_empty, rx_not_empty, tx_not_full}.
REQ-010 CTRL SHALL be: bit0 rx_irq_en, bit1 tx_irq_en, bit2 ovf_irq_en, bit6 rx_flush, bit7 tx_flush; the flush bits self-clear, act in the write cycle, and read back as 0.
REQ-011 Each FIFO SHALL use read and write pointers of clog2(DEPTH) bits that wrap naturally, plus a count of clog2(DEPTH)+1 bits; RX_LEVEL and TX_LEVEL SHALL return the count zero-extended to 8 bits.
REQ-012 A DATA write with tx_count<DEPTH SHALL push write_data; a DATA write when full SHALL be dropped and SHALL set IRQ_STAT.tx_ovf (bit1).
REQ-013 An rx_data_valid pulse with rx_count<DEPTH SHALL push rx_data; when full, the byte SHALL be dropped and IRQ_STAT.rx_ovf (bit0) SHALL be set.
REQ-014 A DATA read SHALL present the RX head combinationally in the same cycle and pop on that clock edge; a DATA read when empty SHALL return 0x00 and leave the FIFO unchanged.
REQ-015 A simultaneous push and pop on the same FIFO SHALL leave its count unchanged, and both operations SHALL take effect; a push and pop on a full FIFO SHALL both succeed.
REQ-016 The TX engine SHALL have the states IDLE, WAIT_ACK and WAIT_DONE.
REQ-017 In IDLE, when tx_count>0 and !tx_busy, the engine SHALL register tx_data=head, pulse tx_data_valid for exactly 1 cycle, and move to WAIT_ACK.
REQ-018 In WAIT_ACK, when tx_busy=1, the engine SHALL pop the TX head and move to WAIT_DONE.
REQ-019 In WAIT_DONE, when tx_busy=0, the engine SHALL move to IDLE; the earliest next pulse SHALL be in the following cycle.
REQ-020 tx_engine_active SHALL be 1 in WAIT_ACK and WAIT_DONE.
REQ-021 tx_flush SHALL clear the TX pointers and count and force the engine to IDLE, with no pop; a CPU push in the same cycle SHALL be discarded.
REQ-022 rx_flush SHALL clear the RX pointers and count; an rx_data_valid pulse in the same cycle SHALL be discarded, with no overflow recorded.
REQ-023 Writing 1 to an IRQ_STAT bit SHALL clear it; if a set event and a clear occur in the same cycle, the set SHALL win.

Reset
REQ-024 On reset_n=0, asynchronously, all pointers, counts, CTRL, IRQ_STAT, tx_data (0x00), tx_data_valid (0) and irq (0) SHALL clear, and the engine SHALL enter IDLE.
REQ-025 FIFO storage SHALL NOT be reset.
REQ-026 Reset asserted mid-transfer SHALL abandon the byte; after release, no tx_data_valid SHALL occur until data is written.

Configuration
REQ-027 With UART_MMIO_IRQ_EN defined, irq SHALL register, one cycle after its cause, the value (rx_irq_en & rx_not_empty) | (tx_irq_en & tx_empty & engine IDLE) | (ovf_irq_en & (rx_ovf|tx_ovf)).
REQ-028 Without UART_MMIO_IRQ_EN, irq SHALL be tied to 0, CTRL bits 0-2 SHALL read 0 and ignore writes, and IRQ_STAT SHALL still record overflows.

Verification
REQ-029 Write 0x41,0x42,0x43 to DATA with tx_busy modeled as 10 cycles after each pulse -> three single-cycle tx_data_valid pulses in order 0x41,0x42,0x43, and TX_LEVEL steps 3,2,1,0.
REQ-030 Push DEPTH+1 rx bytes 0x00..0x10 (DEPTH=16) -> RX_LEVEL=0x10, IRQ_STAT=0x01, and 16 DATA reads return 0x00..0x0F, including wrap after entry 15.
REQ-031 In the same cycle a DATA read and an rx_data_valid arrive with rx_count=16 -> the pop succeeds, the push succeeds, the count stays 16 and no overflow is recorded.
REQ-032 Write CTRL=0x80 while the engine is in WAIT_ACK with 5 bytes queued -> TX_LEVEL=0 and the engine returns to IDLE with no further pulses.
REQ-033 With UART_MMIO_IRQ_EN defined, set CTRL=0x04 and overflow TX -> irq=1 one cycle later; writing IRQ_STAT=0x02 -> irq=0 one cycle after that.
REQ-034 Assert reset_n low mid-WAIT_DONE -> all outputs read 0 immediately; after release, STATUS=0x05.

Source files
------------

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped UART front end with an RX FIFO, a TX FIFO and
// a small TX hand-off engine (IDLE -> WAIT_ACK -> WAIT_DONE).
// Register map: 0x00 STATUS, 0x04 DATA, 0x08 CTRL, 0x0C IRQ_STAT (W1C),
// 0x10 RX_LEVEL, 0x14 TX_LEVEL.
// Optional feature: define UART_MMIO_IRQ_EN to build the interrupt enables
// and the registered irq output; otherwise irq is tied low.
module uart_mmio_ctrl #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            write_data,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [7:0]            read_data,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_busy,
  output logic                  irq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'('h00);
  localparam logic [ADDR_WIDTH-1:0] A_DATA   = ADDR_WIDTH'('h04);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'('h08);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ    = ADDR_WIDTH'('h0C);
  localparam logic [ADDR_WIDTH-1:0] A_RXL    = ADDR_WIDTH'('h10);
  localparam logic [ADDR_WIDTH-1:0] A_TXL    = ADDR_WIDTH'('h14);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} tx_state_e;

  // FIFO storage and state
  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;
  logic          rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  tx_state_e     state_q, state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    ctrl_rd;

  // Bus decode
  logic wr_data, wr_ctrl, wr_irq, rd_data, tx_flush, rx_flush;
  assign wr_data  = write_enable && (addr == A_DATA);
  assign wr_ctrl  = write_enable && (addr == A_CTRL);
  assign wr_irq   = write_enable && (addr == A_IRQ);
  assign rd_data  = read_enable  && (addr == A_DATA);
  assign tx_flush = wr_ctrl && write_data[7];
  assign rx_flush = wr_ctrl && write_data[6];

  // FIFO flags and push/pop qualification; a full FIFO accepts a push only
  // when it is popped in the same cycle.
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, rx_ovf_set, tx_push, tx_pop, tx_ovf_set;
  assign rx_empty   = (rx_count_q == '0);
  assign rx_full    = (rx_count_q == CW'(DEPTH));
  assign tx_empty   = (tx_count_q == '0);
  assign tx_full    = (tx_count_q == CW'(DEPTH));
  assign rx_pop     = rd_data && !rx_empty && !rx_flush;
  assign rx_push    = rx_data_valid && !rx_flush && (!rx_full || rx_pop);
  assign rx_ovf_set = rx_data_valid && !rx_flush && rx_full && !rx_pop;
  assign tx_push    = wr_data && !tx_flush && (!tx_full || tx_pop);
  assign tx_ovf_set = wr_data && !tx_flush && tx_full && !tx_pop;

  // TX engine next-state: launch head byte, wait for busy, wait for idle
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    tx_pop     = 1'b0;
    if (tx_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (!tx_empty && !tx_busy) begin
          tx_data_d  = tx_mem[tx_rd_ptr_q];
          tx_valid_d = 1'b1;
          state_d    = WAIT_ACK;
        end
        WAIT_ACK: if (tx_busy) begin
          tx_pop  = !tx_empty;
          state_d = WAIT_DONE;
        end
        WAIT_DONE: if (!tx_busy) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO pointer/count and overflow-flag next values; flush clears, set beats W1C
  always_comb begin
    rx_wr_ptr_d = rx_flush ? '0 : rx_wr_ptr_q + PW'(rx_push);
    rx_rd_ptr_d = rx_flush ? '0 : rx_rd_ptr_q + PW'(rx_pop);
    rx_count_d  = rx_flush ? '0 : rx_count_q + CW'(rx_push) - CW'(rx_pop);
    tx_wr_ptr_d = tx_flush ? '0 : tx_wr_ptr_q + PW'(tx_push);
    tx_rd_ptr_d = tx_flush ? '0 : tx_rd_ptr_q + PW'(tx_pop);
    tx_count_d  = tx_flush ? '0 : tx_count_q + CW'(tx_push) - CW'(tx_pop);
    rx_ovf_d    = rx_ovf_set || (rx_ovf_q && !(wr_irq && write_data[0]));
    tx_ovf_d    = tx_ovf_set || (tx_ovf_q && !(wr_irq && write_data[1]));
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!reset_n) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_ovf_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      state_q     <= IDLE;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_ovf_q    <= tx_ovf_d;
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  // FIFO storage writes
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; pointers and counts define which entries are valid.
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
    if (tx_push) tx_mem[tx_wr_ptr_q] <= write_data;
  end

`ifdef UART_MMIO_IRQ_EN
  logic [2:0] ctrl_q, ctrl_d;
  logic       irq_q, irq_d;

  // Interrupt enables and the level interrupt computed from registered causes
  always_comb begin
    ctrl_d = wr_ctrl ? write_data[2:0] : ctrl_q;
    irq_d  = (ctrl_q[0] && !rx_empty) ||
             (ctrl_q[1] && tx_empty && (state_q == IDLE)) ||
             (ctrl_q[2] && (rx_ovf_q || tx_ovf_q));
  end

  // Interrupt enable and irq registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end

  assign ctrl_rd = {5'b0, ctrl_q};
  assign irq     = irq_q;
`else
  assign ctrl_rd = 8'h00;
  assign irq     = 1'b0;
`endif

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;

  // Combinational register read mux; DATA returns the RX head or 0 when empty
  always_comb begin
    read_data = 8'h00;
    if (addr == A_STATUS)
      read_data = {3'b0, (state_q != IDLE), rx_full, tx_empty, !rx_empty, !tx_full};
    else if (addr == A_DATA)
      read_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];
    else if (addr == A_CTRL)
      read_data = ctrl_rd;
    else if (addr == A_IRQ)
      read_data = {6'b0, tx_ovf_q, rx_ovf_q};
    else if (addr == A_RXL)
      read_data = 8'(rx_count_q);
    else if (addr == A_TXL)
      read_data = 8'(tx_count_q);
  end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl (DEPTH=16). A queue-based model of
// each FIFO and a simple transmitter model (busy for 10 cycles after each
// start pulse) supply the expected values. Expectations for irq and the CTRL
// enable bits follow the UART_MMIO_IRQ_EN build option.
module tb_uart_mmio_ctrl;
  localparam int DEPTH = 16;
  localparam logic [31:0] A_STATUS = 32'h00, A_DATA = 32'h04, A_CTRL = 32'h08;
  localparam logic [31:0] A_IRQ = 32'h0C, A_RXL = 32'h10, A_TXL = 32'h14;
`ifdef UART_MMIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic [7:0]  write_data;
  logic        write_enable, read_enable;
  logic [7:0]  read_data;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_busy;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Transmitter model: mode 0 = idle, 1 = held busy, 2 = busy 10 cycles per pulse
  int         mode     = 0;
  int         busy_cnt = 0;
  logic [7:0] cap[$];
  bit         prev_valid = 1'b0;
  bit         multi = 1'b0;
  assign tx_busy = (mode == 1) || (mode == 2 && busy_cnt > 0);

  uart_mmio_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .write_data(write_data),
    .write_enable(write_enable), .read_enable(read_enable), .read_data(read_data),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_busy(tx_busy), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_data_valid) begin
      cap.push_back(tx_data);
      if (prev_valid) multi = 1'b1;
      if (mode == 2) busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    prev_valid = tx_data_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    addr = a; write_data = d; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
    addr = a; read_enable = 1'b1;
    #1 d = read_data;
    @(negedge clk);
    read_enable = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    total++; if (tx_data_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_data_valid); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    bus_read(A_STATUS, v);
    total++; if (v !== 8'h05) begin bad++; $display("FAIL reset_status: got %h want 05", v); end
    bus_read(A_RXL, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_rx_level: got %h want 00", v); end
    bus_read(A_TXL, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_tx_level: got %h want 00", v); end
    bus_read(A_IRQ, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_irq_stat: got %h want 00", v); end
    bus_read(A_DATA, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL empty_data_read: got %h want 00", v); end
  endtask

  task automatic test_regs();
    logic [7:0] v;
    bus_write(32'h18, 8'hFF);
    bus_read(32'h18, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL unmapped_read: got %h want 00", v); end
    bus_write(A_CTRL, 8'hC7);
    bus_read(A_CTRL, v);
    total++; if (v !== (IRQ_ON ? 8'h07 : 8'h00)) begin bad++; $display("FAIL ctrl_readback: got %h want %h", v, IRQ_ON ? 8'h07 : 8'h00); end
    bus_write(A_CTRL, 8'h00);
    bus_read(A_STATUS, v);
    total++; if (v !== 8'h05) begin bad++; $display("FAIL status_after_regs: got %h want 05", v); end
  endtask

  task automatic test_rx_random();
    logic [7:0] q[$];
    logic [7:0] b, v, e;
    bit do_rd, do_wr, pop, full, ovf;
    ovf = 1'b0;
    bus_write(A_CTRL, 8'h40);
    bus_write(A_IRQ, 8'h03);
    for (int i = 0; i < 300; i++) begin
      do_wr = ($urandom_range(0, 99) < 60);
      do_rd = ($urandom_range(0, 99) < 35);
      b = 8'($urandom);
      addr = A_DATA; read_enable = do_rd; rx_data = b; rx_data_valid = do_wr;
      #1;
      if (do_rd) begin
        e = (q.size() > 0) ? q[0] : 8'h00;
        total++; if (read_data !== e) begin bad++; $display("FAIL rx_random_read[%0d]: got %h want %h", i, read_data, e); end
      end
      full = (q.size() == DEPTH);
      pop  = do_rd && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (do_wr) begin
        if (!full || pop) q.push_back(b);
        else ovf = 1'b1;
      end
      @(negedge clk);
      read_enable = 1'b0; rx_data_valid = 1'b0;
    end
    bus_read(A_RXL, v);
    total++; if (v !== 8'(q.size())) begin bad++; $display("FAIL rx_random_level: got %h want %h", v, 8'(q.size())); end
    bus_read(A_IRQ, v);
    total++; if (v !== {7'b0, ovf}) begin bad++; $display("FAIL rx_random_ovf: got %h want %h", v, {7'b0, ovf}); end
    while (q.size() > 0) begin
      e = q.pop_front();
      bus_read(A_DATA, v);
      total++; if (v !== e) begin bad++; $display("FAIL rx_random_drain: got %h want %h", v, e); end
    end
    bus_write(A_IRQ, 8'h03);
  endtask

  task automatic test_rx_fill();
    logic [7:0] v;
    bus_write(A_CTRL, 8'h40);
    bus_write(A_IRQ, 8'h03);
    for (int i = 0; i <= DEPTH; i++) begin
      rx_data = 8'(i); rx_data_valid = 1'b1;
      @(negedge clk);
    end
    rx_data_valid = 1'b0;
    bus_read(A_RXL, v);
    total++; if (v !== 8'h10) begin bad++; $display("FAIL rx_fill_level: got %h want 10", v); end
    bus_read(A_IRQ, v);
    total++; if (v !== 8'h01) begin bad++; $display("FAIL rx_fill_ovf: got %h want 01", v); end
    bus_read(A_STATUS, v);
    total++; if (v !== 8'h0F) begin bad++; $display("FAIL rx_fill_status: got %h want 0F", v); end
    // Overflow and W1C of the same bit in one cycle: the set must win
    addr = A_IRQ; write_data = 8'h01; write_enable = 1'b1; rx_data = 8'hEE; rx_data_valid = 1'b1;
    @(negedge clk);
    write_enable = 1'b0; rx_data_valid = 1'b0;
    bus_read(A_IRQ, v);
    total++; if (v !== 8'h01) begin bad++; $display("FAIL w1c_set_wins: got %h want 01", v); end
    bus_write(A_IRQ, 8'h01);
    bus_read(A_IRQ, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL w1c_clear: got %h want 00", v); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(A_DATA, v);
      total++; if (v !== 8'(i)) begin bad++; $display("FAIL rx_fill_read[%0d]: got %h want %h", i, v, 8'(i)); end
    end
    bus_read(A_RXL, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL rx_fill_drained: got %h want 00", v); end
  endtask

  task automatic test_rx_simul();
    logic [7:0] q[$];
    logic [7:0] b, v, e;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      rx_data = b; rx_data_valid = 1'b1;
      @(negedge clk);
    end
    b = 8'($urandom);
    addr = A_DATA; read_enable = 1'b1; rx_data = b; rx_data_valid = 1'b1;
    #1;
    total++; if (read_data !== q[0]) begin bad++; $display("FAIL simul_read: got %h want %h", read_data, q[0]); end
    void'(q.pop_front());
    q.push_back(b);
    @(negedge clk);
    read_enable = 1'b0; rx_data_valid = 1'b0;
    bus_read(A_RXL, v);
    total++; if (v !== 8'h10) begin bad++; $display("FAIL simul_level: got %h want 10", v); end
    bus_read(A_IRQ, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL simul_no_ovf: got %h want 00", v); end
    while (q.size() > 0) begin
      e = q.pop_front();
      bus_read(A_DATA, v);
      total++; if (v !== e) begin bad++; $display("FAIL simul_drain: got %h want %h", v, e); end
    end
  endtask

  task automatic test_tx_basic();
    logic [7:0] v, prev;
    logic [7:0] lv[$];
    logic [7:0] exp_b[3];
    int c;
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    bus_write(A_CTRL, 8'h80);
    mode = 1; busy_cnt = 0; cap.delete(); multi = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(A_DATA, exp_b[i]);
    bus_read(A_TXL, v);
    total++; if (v !== 8'h03) begin bad++; $display("FAIL tx_basic_level3: got %h want 03", v); end
    mode = 2; busy_cnt = 0; prev = 8'h03; c = 0;
    while (!(cap.size() == 3 && prev == 8'h00) && c < 300) begin
      bus_read(A_TXL, v);
      if (v !== prev) begin lv.push_back(v); prev = v; end
      c++;
    end
    total++; if (c >= 300) begin bad++; $display("FAIL tx_basic_timeout: pulses %0d level %h", cap.size(), prev); end
    total++; if (lv.size() != 3) begin bad++; $display("FAIL tx_basic_level_steps: got %0d changes want 3", lv.size()); end
    for (int i = 0; i < 3 && i < lv.size(); i++) begin
      total++; if (lv[i] !== 8'(2 - i)) begin bad++; $display("FAIL tx_basic_level[%0d]: got %h want %h", i, lv[i], 8'(2 - i)); end
    end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      total++; if (cap[i] !== exp_b[i]) begin bad++; $display("FAIL tx_basic_byte[%0d]: got %h want %h", i, cap[i], exp_b[i]); end
    end
    total++; if (multi !== 1'b0) begin bad++; $display("FAIL tx_basic_single_cycle: got multi-cycle pulse want single"); end
  endtask

  task automatic test_tx_random();
    logic [7:0] q[$];
    logic [7:0] b, v;
    int c;
    bus_write(A_CTRL, 8'h80);
    mode = 2; busy_cnt = 0; cap.delete(); multi = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      bus_write(A_DATA, b);
    end
    c = 0;
    while (cap.size() < 12 && c < 600) begin @(negedge clk); c++; end
    total++; if (c >= 600) begin bad++; $display("FAIL tx_random_timeout: got %0d pulses want 12", cap.size()); end
    for (int i = 0; i < 12 && i < cap.size(); i++) begin
      total++; if (cap[i] !== q[i]) begin bad++; $display("FAIL tx_random_byte[%0d]: got %h want %h", i, cap[i], q[i]); end
    end
    repeat (5) @(negedge clk);
    bus_read(A_TXL, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL tx_random_level: got %h want 00", v); end
    bus_read(A_IRQ, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL tx_random_no_ovf: got %h want 00", v); end
    total++; if (multi !== 1'b0) begin bad++; $display("FAIL tx_random_single_cycle: got multi-cycle pulse want single"); end
    repeat (15) @(negedge clk);
  endtask

  task automatic test_tx_flush();
    logic [7:0] v;
    bus_write(A_CTRL, 8'h80);
    mode = 0; busy_cnt = 0; cap.delete();
    for (int i = 0; i < 5; i++) bus_write(A_DATA, 8'(8'h60 + i));
    repeat (2) @(negedge clk);
    total++; if (cap.size() != 1) begin bad++; $display("FAIL flush_first_pulse: got %0d pulses want 1", cap.size()); end
    bus_read(A_TXL, v);
    total++; if (v !== 8'h05) begin bad++; $display("FAIL flush_level_before: got %h want 05", v); end
    bus_read(A_STATUS, v);
    total++; if (v !== 8'h11) begin bad++; $display("FAIL flush_status_wait_ack: got %h want 11", v); end
    cap.delete();
    bus_write(A_CTRL, 8'h80);
    bus_read(A_TXL, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL flush_level_after: got %h want 00", v); end
    bus_read(A_STATUS, v);
    total++; if (v !== 8'h05) begin bad++; $display("FAIL flush_status_idle: got %h want 05", v); end
    mode = 2;
    repeat (30) @(negedge clk);
    total++; if (cap.size() != 0) begin bad++; $display("FAIL flush_no_pulses: got %0d pulses want 0", cap.size()); end
  endtask

  task automatic test_irq();
    logic [7:0] v;
    bus_write(A_CTRL, 8'h80);
    bus_write(A_IRQ, 8'h03);
    mode = 1; busy_cnt = 0;
    bus_write(A_CTRL, 8'h04);
    bus_read(A_CTRL, v);
    total++; if (v !== (IRQ_ON ? 8'h04 : 8'h00)) begin bad++; $display("FAIL irq_ctrl_readback: got %h want %h", v, IRQ_ON ? 8'h04 : 8'h00); end
    for (int i = 0; i < DEPTH; i++) bus_write(A_DATA, 8'(i));
    bus_read(A_TXL, v);
    total++; if (v !== 8'h10) begin bad++; $display("FAIL irq_tx_full_level: got %h want 10", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_before_ovf: got %b want 0", irq); end
    bus_write(A_DATA, 8'hAA);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_same_cycle: got %b want 0", irq); end
    @(negedge clk);
    total++; if (irq !== IRQ_ON) begin bad++; $display("FAIL irq_raise: got %b want %b", irq, IRQ_ON); end
    bus_read(A_IRQ, v);
    total++; if (v !== 8'h02) begin bad++; $display("FAIL irq_tx_ovf_stat: got %h want 02", v); end
    bus_read(A_TXL, v);
    total++; if (v !== 8'h10) begin bad++; $display("FAIL irq_ovf_dropped: got %h want 10", v); end
    bus_write(A_IRQ, 8'h02);
    total++; if (irq !== IRQ_ON) begin bad++; $display("FAIL irq_hold: got %b want %b", irq, IRQ_ON); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq); end
    bus_read(A_IRQ, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL irq_stat_cleared: got %h want 00", v); end
    bus_write(A_CTRL, 8'h80);
    mode = 0;
  endtask

  task automatic test_reset_midxfer();
    logic [7:0] v;
    int c;
    bus_write(A_CTRL, 8'h80);
    mode = 2; busy_cnt = 0; cap.delete();
    bus_write(A_DATA, 8'h5A);
    c = 0;
    while (cap.size() < 1 && c < 20) begin @(negedge clk); c++; end
    total++; if (c >= 20) begin bad++; $display("FAIL midxfer_pulse_timeout: got %0d pulses want 1", cap.size()); end
    repeat (3) @(negedge clk);
    bus_read(A_STATUS, v);
    total++; if (v !== 8'h15) begin bad++; $display("FAIL midxfer_wait_done: got %h want 15", v); end
    reset_n = 1'b0;
    #1;
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL midxfer_tx_data: got %h want 00", tx_data); end
    total++; if (tx_data_valid !== 1'b0) begin bad++; $display("FAIL midxfer_tx_valid: got %b want 0", tx_data_valid); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL midxfer_irq: got %b want 0", irq); end
    @(negedge clk);
    mode = 0; busy_cnt = 0;
    reset_n = 1'b1;
    bus_read(A_STATUS, v);
    total++; if (v !== 8'h05) begin bad++; $display("FAIL midxfer_status_after: got %h want 05", v); end
    cap.delete();
    mode = 2;
    repeat (20) @(negedge clk);
    total++; if (cap.size() != 0) begin bad++; $display("FAIL midxfer_no_pulse: got %0d pulses want 0", cap.size()); end
  endtask

  initial begin
    reset_n = 1'b0;
    addr = '0; write_data = '0; write_enable = 1'b0; read_enable = 1'b0;
    rx_data = '0; rx_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_regs();
    test_rx_random();
    test_rx_fill();
    test_rx_simul();
    test_tx_basic();
    test_tx_random();
    test_tx_flush();
    test_irq();
    test_reset_midxfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
